err_cnt_ctrl: RTL and testbench
===============================

# err_cnt_ctrl

Sequencer and configuration controller for the UART receiver's parity and stop-bit error counters. It qualifies per-frame error flags into single-cycle increment strobes, serialises software snapshot/clear requests from the APB register file against those strobes, holds atomic snapshot registers, and raises a sticky threshold interrupt. It sits between the RX frame logic, the error counter instances and the APB register file.

## Interface

- CNT_W, 16, width of the counters, snapshots and threshold

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_en  in  1  global enable for error accounting
- cfg_irq_en  in  1  threshold interrupt enable
- thr  in  CNT_W  interrupt threshold; 0 disables
- frame_done  in  1  one-cycle pulse per received frame
- par_err  in  1  parity error flag, valid with frame_done
- stp_err  in  1  stop-bit error flag, valid with frame_done
- par_cnt  in  CNT_W  current parity error count
- stp_cnt  in  CNT_W  current stop-bit error count
- ctr_en  out  1  counter enable
- ctr_edge_done  out  1  counter increment strobe
- ctr_par_err  out  1  parity flag paired with the strobe
- ctr_stp_err  out  1  stop flag paired with the strobe
- ctr_clr  out  1  synchronous counter clear
- sw_req  in  1  software request, level, held until sw_ack
- sw_op  in  2  00 snapshot, 01 clear, 10 snapshot+clear, 11 reserved
- sw_ack  out  1  one-cycle completion pulse
- busy  out  1  FSM not in IDLE
- snap_par  out  CNT_W  parity count snapshot
- snap_stp  out  CNT_W  stop-bit count snapshot
- ovf  out  1  sticky: frame event dropped
- irq  out  1  sticky threshold interrupt
- irq_clr  in  1  clears irq and ovf

## Operation

- FSM states: IDLE, WAIT, CAPT, ACK.
  - IDLE -> WAIT when sw_req = 1. sw_op is latched at this transition.
  - WAIT -> CAPT, CAPT -> ACK, and ACK -> IDLE each take exactly one cycle.
- Strobe path:
  - ctr_edge_done is registered: ctr_edge_done <= cfg_en & (state == IDLE) & (frame_done | pend_v).
  - ctr_par_err and ctr_stp_err are registered alongside ctr_edge_done from the same source. pend_v has priority over frame_done.
- Pending slot:
  - 1-deep, holding pend_v, pend_par and pend_stp.
  - A frame_done is loaded into the slot if it arrives while the FSM is not IDLE, or in an IDLE cycle where pend_v is being issued.
  - A frame_done that arrives while pend_v is already set and not being issued is dropped, and ovf is set.
- ctr_en = registered cfg_en. While cfg_en = 0, frame_done is ignored and the pending slot is flushed.
- CAPT state:
  - For op 00 and 10: snap_par <= par_cnt and snap_stp <= stp_cnt.
  - For op 01 and 10: ctr_clr = 1 for this one cycle.
  - For op 11: no capture, no clear; the request is still acknowledged.
  - ctr_clr is decoded from the state register.
- Ordering guarantees:
  - ctr_edge_done is never asserted in WAIT, CAPT or ACK, so it never coincides with ctr_clr.
  - A strobe issued in the cycle of request acceptance is included in the snapshot.
  - Events held pending across a clear are counted after the clear.
- Interrupt:
  - Condition: cfg_irq_en & (thr != 0) & (par_cnt >= thr | stp_cnt >= thr), using an unsigned compare.
  - The condition sets irq, which is registered and sticky.
  - irq_clr clears irq and ovf. If set and clear occur in the same cycle, set wins.
- Counter wrap-around belongs to the counters. This block performs no saturation.
- Reset:
  - Asserting rst at any time forces IDLE.
  - All outputs, the snapshot registers and the pending slot go to 0.
  - An in-flight request is aborted with no sw_ack.

## Timing

- frame_done at cycle N (IDLE, cfg_en = 1) -> ctr_edge_done at N+1 -> count visible at N+2.
- sw_req sampled in IDLE at cycle T:
  - WAIT at T+1.
  - CAPT at T+2: snapshot captured at the end of T+2; ctr_clr high during T+2.
  - sw_ack at T+3.
  - IDLE at T+4.
- Requester handshake: sw_req must drop in the sw_ack cycle. If sw_req is still high in the IDLE cycle at T+4, it is a new request.
- busy = 1 from T+1 through T+3.
- A pending event is issued as ctr_edge_done at T+5.
- irq rises 1 cycle after the count crossing becomes visible.

## Test plan

- Error frame: frame_done with par_err = 1, stp_err = 0 at cycle 10 -> ctr_edge_done = 1 and ctr_par_err = 1 at cycle 11; no strobe at any other cycle.
- Snapshot+clear with race: par_cnt = 5, op 10 requested at T, and a strobe at T drives par_cnt to 6 at T+1 -> snap_par = 6, ctr_clr high only at T+2, sw_ack only at T+3.
- Pending and overflow: frame_done at T+1 and at T+2 during op 01 -> the first event is issued at T+5, the second is dropped, and ovf = 1.
- Threshold interrupt: thr = 3, cfg_irq_en = 1, stp_cnt steps 2 -> 3 -> irq = 1 the next cycle; irq_clr asserted while stp_cnt >= 3 -> irq stays 1; thr = 0 -> irq never sets.
- Reserved op: op 11 -> sw_ack at T+3, snapshots unchanged, ctr_clr never asserted.
- Reset abort: rst asserted during CAPT -> IDLE immediately, all outputs 0, no sw_ack; after release, a new request completes normally.

Source files
------------

// File: rtl/err_cnt_ctrl_if.sv
// Software request handshake between the APB register file
// and the error-counter controller.
interface err_cnt_ctrl_if;
  logic       sw_req;
  logic [1:0] sw_op;
  logic       sw_ack;
  logic       busy;

  modport master (
    output sw_req,
    output sw_op,
    input  sw_ack,
    input  busy
  );

  modport slave (
    input  sw_req,
    input  sw_op,
    output sw_ack,
    output busy
  );
endinterface

// File: rtl/err_cnt_ctrl.sv
// UART RX error-counter sequencer: strobe qualification, pending slot,
// snapshot/clear FSM and sticky threshold interrupt.
module err_cnt_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic             cfg_irq_en,
  input  logic [CNT_W-1:0] thr,
  input  logic             frame_done,
  input  logic             par_err,
  input  logic             stp_err,
  input  logic [CNT_W-1:0] par_cnt,
  input  logic [CNT_W-1:0] stp_cnt,
  output logic             ctr_en,
  output logic             ctr_edge_done,
  output logic             ctr_par_err,
  output logic             ctr_stp_err,
  output logic             ctr_clr,
  err_cnt_ctrl_if.slave    sw,
  output logic [CNT_W-1:0] snap_par,
  output logic [CNT_W-1:0] snap_stp,
  output logic             ovf,
  output logic             irq,
  input  logic             irq_clr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             pend_v_q, pend_v_d;
  logic             pend_par_q, pend_par_d;
  logic             pend_stp_q, pend_stp_d;
  logic             edge_q, edge_d;
  logic             epar_q, epar_d;
  logic             estp_q, estp_d;
  logic             en_q;
  logic [CNT_W-1:0] snap_par_q, snap_par_d;
  logic [CNT_W-1:0] snap_stp_q, snap_stp_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;

  logic idle, capt, drop, irq_set;

  assign idle = (state_q == S_IDLE);
  assign capt = (state_q == S_CAPT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sw.sw_req) state_d = S_WAIT;
      S_WAIT:  state_d = S_CAPT;
      S_CAPT:  state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase
    op_d = (idle && sw.sw_req) ? sw.sw_op : op_q;
  end

  // Pending entry wins over a same-cycle frame, which then takes the slot.
  always_comb begin
    edge_d = cfg_en & idle & (frame_done | pend_v_q);
    epar_d = edge_d & (pend_v_q ? pend_par_q : par_err);
    estp_d = edge_d & (pend_v_q ? pend_stp_q : stp_err);
  end

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_par_d = pend_par_q;
    pend_stp_d = pend_stp_q;
    drop       = 1'b0;
    if (!cfg_en) begin
      pend_v_d   = 1'b0;
      pend_par_d = 1'b0;
      pend_stp_d = 1'b0;
    end else begin
      if (idle && pend_v_q) pend_v_d = 1'b0;
      if (frame_done) begin
        if (!idle && pend_v_q) begin
          drop = 1'b1;
        end else if (!idle || pend_v_q) begin
          pend_v_d   = 1'b1;
          pend_par_d = par_err;
          pend_stp_d = stp_err;
        end
      end
    end
  end

  always_comb begin
    snap_par_d = snap_par_q;
    snap_stp_d = snap_stp_q;
    if (capt && (op_q == 2'b00 || op_q == 2'b10)) begin
      snap_par_d = par_cnt;
      snap_stp_d = stp_cnt;
    end
  end

  always_comb begin
    irq_set = cfg_irq_en && (thr != '0) &&
              ((par_cnt >= thr) || (stp_cnt >= thr));
    irq_d   = irq_set | (irq_q & ~irq_clr);
    ovf_d   = drop | (ovf_q & ~irq_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      pend_v_q   <= 1'b0;
      pend_par_q <= 1'b0;
      pend_stp_q <= 1'b0;
      edge_q     <= 1'b0;
      epar_q     <= 1'b0;
      estp_q     <= 1'b0;
      en_q       <= 1'b0;
      snap_par_q <= '0;
      snap_stp_q <= '0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pend_v_q   <= pend_v_d;
      pend_par_q <= pend_par_d;
      pend_stp_q <= pend_stp_d;
      edge_q     <= edge_d;
      epar_q     <= epar_d;
      estp_q     <= estp_d;
      en_q       <= cfg_en;
      snap_par_q <= snap_par_d;
      snap_stp_q <= snap_stp_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
    end
  end

  assign ctr_en        = en_q;
  assign ctr_edge_done = edge_q;
  assign ctr_par_err   = epar_q;
  assign ctr_stp_err   = estp_q;
  assign ctr_clr       = capt & (op_q == 2'b01 || op_q == 2'b10);
  assign sw.sw_ack     = (state_q == S_ACK);
  assign sw.busy       = ~idle;
  assign snap_par      = snap_par_q;
  assign snap_stp      = snap_stp_q;
  assign ovf           = ovf_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_err_cnt_ctrl.sv
// Directed bench for err_cnt_ctrl: strobe vector table plus
// hand sequences for request, pending, interrupt and reset cases.
module tb_err_cnt_ctrl;
  logic        clk, rst;
  logic        cfg_en, cfg_irq_en;
  logic [15:0] thr, par_cnt, stp_cnt;
  logic        frame_done, par_err, stp_err;
  logic        ctr_en, ctr_edge_done, ctr_par_err, ctr_stp_err;
  logic        ctr_clr;
  logic [15:0] snap_par, snap_stp;
  logic        ovf, irq, irq_clr;

  err_cnt_ctrl_if sw();

  err_cnt_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_en(cfg_en), .cfg_irq_en(cfg_irq_en),
    .thr(thr),
    .frame_done(frame_done),
    .par_err(par_err), .stp_err(stp_err),
    .par_cnt(par_cnt), .stp_cnt(stp_cnt),
    .ctr_en(ctr_en),
    .ctr_edge_done(ctr_edge_done),
    .ctr_par_err(ctr_par_err),
    .ctr_stp_err(ctr_stp_err),
    .ctr_clr(ctr_clr),
    .sw(sw),
    .snap_par(snap_par), .snap_stp(snap_stp),
    .ovf(ovf), .irq(irq), .irq_clr(irq_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic en, fd, pe, se;
    logic x_edge, x_par, x_stp, x_en;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n;
    vt[0] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1};
    vt[1] = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b1};
    vt[2] = '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1};
    vt[3] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b1};
    vt[4] = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b1};
    vt[5] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1};
    vt[6] = '{1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0};
    vt[7] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1};

    rst = 1'b1;
    cfg_en = 1'b0; cfg_irq_en = 1'b0; thr = '0;
    frame_done = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    par_cnt = '0; stp_cnt = '0; irq_clr = 1'b0;
    sw.sw_req = 1'b0; sw.sw_op = 2'b00;
    tick(); tick();

    chk("rst_en", ctr_en, 0);
    chk("rst_edge", ctr_edge_done, 0);
    chk("rst_clr", ctr_clr, 0);
    chk("rst_ack", sw.sw_ack, 0);
    chk("rst_busy", sw.busy, 0);
    chk("rst_snap", {snap_par, snap_stp}, 0);
    chk("rst_ovf_irq", {ovf, irq}, 0);

    rst = 1'b0;
    cfg_en = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      cfg_en = vt[i].en;
      frame_done = vt[i].fd;
      par_err = vt[i].pe;
      stp_err = vt[i].se;
      tick();
      chk($sformatf("vec%0d_edge", i), ctr_edge_done, vt[i].x_edge);
      chk($sformatf("vec%0d_par", i), ctr_par_err, vt[i].x_par);
      chk($sformatf("vec%0d_stp", i), ctr_stp_err, vt[i].x_stp);
      chk($sformatf("vec%0d_en", i), ctr_en, vt[i].x_en);
    end
    cfg_en = 1'b1; frame_done = 1'b0;
    tick();

    // single error frame gives exactly one strobe
    frame_done = 1'b1; par_err = 1'b1; stp_err = 1'b0;
    tick();
    frame_done = 1'b0; par_err = 1'b0;
    chk("one_par", {ctr_edge_done, ctr_par_err, ctr_stp_err}, 3'b110);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ctr_edge_done) n++;
    end
    chk("one_extra", n, 0);

    // snapshot+clear racing a strobe at T
    frame_done = 1'b1; par_err = 1'b1;
    tick();
    frame_done = 1'b0; par_err = 1'b0;
    par_cnt = 16'd5; stp_cnt = 16'd9;
    sw.sw_req = 1'b1; sw.sw_op = 2'b10;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sc_edge%0d", k), ctr_edge_done, k == 0);
      chk($sformatf("sc_clr%0d", k), ctr_clr, k == 2);
      chk($sformatf("sc_ack%0d", k), sw.sw_ack, k == 3);
      chk($sformatf("sc_busy%0d", k), sw.busy, k >= 1 && k <= 3);
      if (k == 3) sw.sw_req = 1'b0;
      if (k < 4) tick();
      if (k == 0) par_cnt = 16'd6;
      if (k == 2) begin par_cnt = '0; stp_cnt = '0; end
    end
    chk("sc_snap_par", snap_par, 16'd6);
    chk("sc_snap_stp", snap_stp, 16'd9);

    // op 01: one event pending, second dropped
    sw.sw_req = 1'b1; sw.sw_op = 2'b01;
    tick();
    frame_done = 1'b1; par_err = 1'b0; stp_err = 1'b1;
    tick();
    frame_done = 1'b1; par_err = 1'b1; stp_err = 1'b0;
    chk("pd_clr", ctr_clr, 1);
    chk("pd_ovf0", ovf, 0);
    tick();
    frame_done = 1'b0; par_err = 1'b0;
    chk("pd_ack", sw.sw_ack, 1);
    chk("pd_ovf1", ovf, 1);
    sw.sw_req = 1'b0;
    tick();
    chk("pd_edge4", ctr_edge_done, 0);
    tick();
    chk("pd_edge5", {ctr_edge_done, ctr_par_err, ctr_stp_err}, 3'b101);
    tick();
    chk("pd_edge6", ctr_edge_done, 0);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("pd_ovf_clr", ovf, 0);

    // op 00: pending issue and reload in the same IDLE cycle
    par_cnt = 16'd20; stp_cnt = 16'd21;
    sw.sw_req = 1'b1; sw.sw_op = 2'b00;
    tick();
    frame_done = 1'b1; par_err = 1'b1;
    tick();
    frame_done = 1'b0; par_err = 1'b0;
    tick();
    chk("ld_ack", sw.sw_ack, 1);
    sw.sw_req = 1'b0;
    tick();
    frame_done = 1'b1; stp_err = 1'b1;
    chk("ld_edge4", ctr_edge_done, 0);
    tick();
    frame_done = 1'b0; stp_err = 1'b0;
    chk("ld_edge5", {ctr_edge_done, ctr_par_err, ctr_stp_err}, 3'b110);
    tick();
    chk("ld_edge6", {ctr_edge_done, ctr_par_err, ctr_stp_err}, 3'b101);
    tick();
    chk("ld_edge7", ctr_edge_done, 0);
    chk("ld_snap", {snap_par, snap_stp}, {16'd20, 16'd21});
    chk("ld_ovf", ovf, 0);

    // reserved op: acknowledged, no capture, no clear
    par_cnt = 16'd77; stp_cnt = 16'd88;
    sw.sw_req = 1'b1; sw.sw_op = 2'b11;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (ctr_clr) n++;
      chk($sformatf("rs_ack%0d", k), sw.sw_ack, k == 3);
      if (k == 3) sw.sw_req = 1'b0;
      if (k < 4) tick();
    end
    chk("rs_clr", n, 0);
    chk("rs_snap", {snap_par, snap_stp}, {16'd20, 16'd21});

    // threshold interrupt
    par_cnt = '0; stp_cnt = 16'd2; thr = 16'd3; cfg_irq_en = 1'b1;
    tick();
    chk("irq_below", irq, 0);
    stp_cnt = 16'd3;
    chk("irq_same", irq, 0);
    tick();
    chk("irq_rise", irq, 1);
    irq_clr = 1'b1;
    tick();
    chk("irq_setwins", irq, 1);
    stp_cnt = '0;
    tick();
    irq_clr = 1'b0;
    chk("irq_cleared", irq, 0);
    thr = '0; par_cnt = 16'd100; stp_cnt = 16'd100;
    tick(); tick();
    chk("irq_thr0", irq, 0);
    thr = 16'd3; cfg_irq_en = 1'b0;
    tick();
    chk("irq_dis", irq, 0);
    cfg_irq_en = 1'b1; par_cnt = 16'd3; stp_cnt = '0;
    tick();
    chk("irq_par_eq", irq, 1);
    par_cnt = '0; irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_clr2", irq, 0);
    thr = 16'h8000; par_cnt = 16'hffff;
    tick();
    chk("irq_unsigned", irq, 1);
    par_cnt = 16'h7fff; irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_below_big", irq, 0);
    cfg_irq_en = 1'b0; par_cnt = '0;

    // reset during CAPT aborts the request
    par_cnt = 16'd4; stp_cnt = 16'd5;
    sw.sw_req = 1'b1; sw.sw_op = 2'b10;
    tick(); tick();
    chk("ab_capt", ctr_clr, 1);
    #2 rst = 1'b1;
    #1;
    chk("ab_busy", sw.busy, 0);
    chk("ab_clr", ctr_clr, 0);
    chk("ab_ack", sw.sw_ack, 0);
    chk("ab_snap", {snap_par, snap_stp}, 0);
    chk("ab_outs", {ctr_en, ctr_edge_done, ovf, irq}, 0);
    sw.sw_req = 1'b0;
    tick();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (sw.sw_ack || sw.busy) n++;
    end
    chk("ab_noack", n, 0);
    sw.sw_req = 1'b1; sw.sw_op = 2'b00;
    tick(); tick(); tick();
    chk("ab_new_ack", sw.sw_ack, 1);
    sw.sw_req = 1'b0;
    tick();
    chk("ab_new_snap", {snap_par, snap_stp}, {16'd4, 16'd5});
    chk("ab_idle", sw.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
